reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/rob_pkg.sv | 19 +
 rtl/rob_ptr.sv | 21 ++
 rtl/reorder_buffer.sv | 134 +++++++++++++
 tb/tb_reorder_buffer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: default widths and the opcode set
// carried through each entry.
package rob_pkg;

  localparam int ROB_DEPTH  = 8;
  localparam int ROB_DATA_W = 8;
  localparam int ROB_REG_W  = 4;
  localparam int ROB_OPC_W  = 4;

  typedef enum logic [ROB_OPC_W-1:0] {
    SUB   = 4'b0000,
    ADD   = 4'b0001,
    MUL   = 4'b0010,
    DIV   = 4'b0011,
    STORE = 4'b0100,
    LOAD  = 4'b0101
  } rob_opcode_e;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping pointer for the reorder buffer: clears to zero, or advances by one
// modulo 2**W (W = TAG_W, so the wrap falls at DEPTH).
module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries are allocated at tail, completed by
// result broadcasts, and retired from head once their result is ready.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter  int DEPTH  = ROB_DEPTH,
  parameter  int DATA_W = ROB_DATA_W,
  parameter  int REG_W  = ROB_REG_W,
  parameter  int OPC_W  = ROB_OPC_W,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [OPC_W-1:0]  alloc_opcode,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_value,
  output logic              cm_valid,
  input  logic              cm_ready,
  output logic [OPC_W-1:0]  cm_opcode,
  output logic [REG_W-1:0]  cm_dest,
  output logic [DATA_W-1:0] cm_value,
  input  logic              flush,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  ready_q;
  logic [OPC_W-1:0]  opc_q   [DEPTH];
  logic [REG_W-1:0]  dest_q  [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic             do_alloc;
  logic             do_commit;
  logic             wb_hit;

  // Handshakes: alloc and commit each transfer on a rising edge where
  // valid && ready; alloc_ready and cm_valid come from registered state only,
  // so a same-cycle commit never opens a slot for a same-cycle allocation.
  assign alloc_ready = (count < FULL_CNT);
  assign alloc_tag   = tail;
  assign cm_valid    = busy_q[head] && ready_q[head];
  assign cm_opcode   = opc_q[head];
  assign cm_dest     = dest_q[head];
  assign cm_value    = value_q[head];
  assign empty       = (count == '0);

  assign do_alloc  = alloc_valid && alloc_ready && !flush;
  assign do_commit = cm_valid && cm_ready && !flush;
  assign wb_hit    = wb_valid && busy_q[wb_tag] && !flush;

  rob_ptr #(.W(TAG_W)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (do_commit),
    .ptr (head)
  );

  rob_ptr #(.W(TAG_W)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (do_alloc),
    .ptr (tail)
  );

  // Later assignments win: commit clears after a writeback to head, and an
  // allocation overrides anything aimed at a free tail slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opc_q[i]   <= '0;
        dest_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else if (flush) begin
      busy_q  <= '0;
      ready_q <= '0;
    end else begin
      if (wb_hit) begin
        ready_q[wb_tag] <= 1'b1;
        value_q[wb_tag] <= wb_value;
      end
      if (do_commit) begin
        busy_q[head]  <= 1'b0;
        ready_q[head] <= 1'b0;
      end
      if (do_alloc) begin
        busy_q[tail]  <= 1'b1;
        ready_q[tail] <= 1'b0;
        opc_q[tail]   <= alloc_opcode;
        dest_q[tail]  <= alloc_dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      case ({do_alloc, do_commit})
        2'b10:   count <= count + (TAG_W+1)'(1);
        2'b01:   count <= count - (TAG_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Operand lookup sees a result on the bus in the same cycle it is broadcast.
  always_comb begin
    rd_ready = busy_q[rd_tag] && ready_q[rd_tag];
    rd_value = value_q[rd_tag];
    if (wb_valid && (wb_tag == rd_tag)) begin
      rd_ready = 1'b1;
      rd_value = wb_value;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios then random
// traffic, all checked against a queue-of-instructions reference model.
module tb_reorder_buffer;
  import rob_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int REG_W  = 4;
  localparam int OPC_W  = 4;
  localparam int TAG_W  = 3;
  localparam int CM_W   = OPC_W + REG_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [OPC_W-1:0]  alloc_opcode;
  logic [REG_W-1:0]  alloc_dest;
  logic [TAG_W-1:0]  alloc_tag;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_value;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_value;
  logic              cm_valid;
  logic              cm_ready;
  logic [OPC_W-1:0]  cm_opcode;
  logic [REG_W-1:0]  cm_dest;
  logic [DATA_W-1:0] cm_value;
  logic              flush;
  logic [TAG_W:0]    count;
  logic              empty;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  reorder_buffer #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .OPC_W(OPC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_opcode(alloc_opcode), .alloc_dest(alloc_dest), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_value(rd_value),
    .cm_valid(cm_valid), .cm_ready(cm_ready),
    .cm_opcode(cm_opcode), .cm_dest(cm_dest), .cm_value(cm_value),
    .flush(flush), .count(count), .empty(empty)
  );

  // ---------------- reference model ----------------
  // In-flight instructions, oldest first; tags are handed out round-robin.
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [OPC_W-1:0]  opc;
    logic [REG_W-1:0]  dst;
    bit                rdy;
    logic [DATA_W-1:0] val;
  } ent_t;

  ent_t             m_q[$];
  logic [TAG_W-1:0] m_next;
  logic [CM_W-1:0]  exp_q[$];
  int               tests = 0;
  int               fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int               n;
    logic             exp_rr;
    logic [DATA_W-1:0] exp_rv;
    n = m_q.size();
    chk("alloc_ready", alloc_ready, 32'(n < DEPTH));
    chk("alloc_tag", alloc_tag, 32'(m_next));
    chk("count", count, 32'(n));
    chk("empty", empty, 32'(n == 0));
    chk("cm_valid", cm_valid, 32'(n > 0 && m_q[0].rdy));
    if (n > 0 && m_q[0].rdy) begin
      chk("cm_fields", {cm_opcode, cm_dest, cm_value}, {m_q[0].opc, m_q[0].dst, m_q[0].val});
    end
    if (wb_valid && wb_tag == rd_tag) begin
      chk("rd_bypass_ready", rd_ready, 1);
      chk("rd_bypass_value", rd_value, 32'(wb_value));
    end else begin
      exp_rr = 1'b0;
      exp_rv = '0;
      foreach (m_q[i]) begin
        if (m_q[i].tag == rd_tag && m_q[i].rdy) begin
          exp_rr = 1'b1;
          exp_rv = m_q[i].val;
        end
      end
      chk("rd_ready", rd_ready, 32'(exp_rr));
      if (exp_rr) chk("rd_value", rd_value, 32'(exp_rv));
    end
  endtask

  task automatic model_update();
    ent_t e;
    int   n0;
    n0 = m_q.size();
    if (rst || flush) begin
      m_q.delete();
      m_next = '0;
      return;
    end
    if (cm_ready && n0 > 0 && m_q[0].rdy) begin
      e = m_q.pop_front();
      exp_q.push_back({e.opc, e.dst, e.val});
    end
    if (wb_valid) begin
      foreach (m_q[i]) begin
        if (m_q[i].tag == wb_tag) begin
          e = m_q[i];
          e.rdy = 1'b1;
          e.val = wb_value;
          m_q[i] = e;
        end
      end
    end
    if (alloc_valid && n0 < DEPTH) begin
      e.tag = m_next;
      e.opc = alloc_opcode;
      e.dst = alloc_dest;
      e.rdy = 1'b0;
      e.val = '0;
      m_q.push_back(e);
      m_next = m_next + 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic f, input logic av,
                      input logic [OPC_W-1:0] op, input logic [REG_W-1:0] dst,
                      input logic wv, input logic [TAG_W-1:0] wt,
                      input logic [DATA_W-1:0] wval, input logic [TAG_W-1:0] rt,
                      input logic cr);
    @(negedge clk);
    rst = r; flush = f;
    alloc_valid = av; alloc_opcode = op; alloc_dest = dst;
    wb_valid = wv; wb_tag = wt; wb_value = wval;
    rd_tag = rt; cm_ready = cr;
    #1;
    check_outputs();
    model_update();
  endtask

  task automatic idle(input logic cr);
    step(0, 0, 0, '0, '0, 0, '0, '0, '0, cr);
  endtask

  task automatic alloc(input logic [OPC_W-1:0] op, input logic [REG_W-1:0] dst);
    step(0, 0, 1, op, dst, 0, '0, '0, '0, 0);
  endtask

  task automatic wb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v, input logic cr);
    step(0, 0, 0, '0, '0, 1, t, v, '0, cr);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [CM_W-1:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (cm_valid === 1'b1 && cm_ready && !rst && !flush) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL commit_unexpected: got %0h expected none", {cm_opcode, cm_dest, cm_value});
        end else begin
          exp = exp_q.pop_front();
          chk("commit", {cm_opcode, cm_dest, cm_value}, 32'(exp));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic             r, f, av, wv, cr;
    logic [OPC_W-1:0] op;
    logic [REG_W-1:0] dst;
    logic [TAG_W-1:0] wt, rt;
    logic [DATA_W-1:0] wval;

    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_opcode = '0; alloc_dest = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_value = '0; rd_tag = '0; cm_ready = 1'b0;
    repeat (2) @(posedge clk);
    m_q.delete();
    m_next = '0;

    idle(0);
    chk("reset_cm_value", cm_value, 0);

    // Three allocations, then out-of-order results retire in order.
    alloc(ADD, 4'd1);
    alloc(MUL, 4'd2);
    alloc(SUB, 4'd3);
    idle(0);
    chk("three_alloc_count", count, 3);
    chk("three_alloc_cm_valid", cm_valid, 0);
    wb(3'd1, 8'h2A, 1);
    chk("tag1_done_no_commit", cm_valid, 0);
    wb(3'd0, 8'h05, 1);
    chk("head_wb_same_cycle", cm_valid, 0);
    idle(1);
    chk("retire0", {cm_valid, cm_dest, cm_value}, {1'b1, 4'd1, 8'h05});
    idle(1);
    chk("retire1", {cm_valid, cm_dest, cm_value}, {1'b1, 4'd2, 8'h2A});

    // Same-cycle bypass on the lookup port.
    step(0, 0, 0, '0, '0, 1, 3'd2, 8'h7F, 3'd2, 0);
    chk("bypass_ready", rd_ready, 1);
    chk("bypass_value", rd_value, 8'h7F);
    idle(1);

    // Fill to capacity; an alloc beside a commit is still refused.
    step(1, 0, 0, '0, '0, 0, '0, '0, '0, 0);
    for (int i = 0; i < DEPTH; i++) alloc(4'($urandom_range(0, 5)), 4'(i));
    wb(3'd0, 8'h11, 0);
    step(0, 0, 1, ADD, 4'd9, 0, '0, '0, '0, 1);
    chk("full_alloc_ready", alloc_ready, 0);
    idle(0);
    chk("after_commit_ready", alloc_ready, 1);
    chk("after_commit_tag", alloc_tag, 0);
    alloc(LOAD, 4'd10);
    idle(0);
    chk("refill_count", count, 8);

    // Reset in the middle of a commit from a full buffer.
    wb(3'd1, 8'h22, 0);
    step(1, 0, 0, '0, '0, 0, '0, '0, '0, 1);
    idle(0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_cm_valid", cm_valid, 0);
    chk("rst_cm_value", cm_value, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);

    // Flush with five busy entries and a concurrent writeback.
    for (int i = 0; i < 5; i++) alloc(STORE, 4'(i));
    wb(3'd0, 8'h33, 0);
    step(0, 1, 1, DIV, 4'd7, 1, 3'd2, 8'h44, '0, 1);
    idle(0);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_alloc_tag", alloc_tag, 0);
    for (int i = 0; i < 3; i++) alloc(ADD, 4'(i));
    step(0, 0, 0, '0, '0, 0, '0, '0, 3'd2, 0);
    chk("flush_stale_wb", rd_ready, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      r    = ($urandom_range(0, 499) == 0);
      f    = ($urandom_range(0, 59) == 0);
      av   = ($urandom_range(0, 99) < 55);
      op   = OPC_W'($urandom_range(0, 5));
      dst  = REG_W'($urandom);
      wv   = ($urandom_range(0, 99) < 60);
      wval = DATA_W'($urandom);
      cr   = ($urandom_range(0, 99) < 70);
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
        wt = m_q[$urandom_range(0, m_q.size() - 1)].tag;
      else
        wt = TAG_W'($urandom);
      if (m_q.size() > 0 && $urandom_range(0, 1) == 0)
        rt = m_q[$urandom_range(0, m_q.size() - 1)].tag;
      else
        rt = TAG_W'($urandom);
      step(r, f, av, op, dst, wv, wt, wval, rt, cr);
    end
    idle(0);
    idle(0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
